instr_class_counter: RTL and testbench

//  Serial instruction-stream profiler. Shifts in MIPS instruction words one bit
//  per valid cycle (MSB first), classifies each complete word by opcode
//  (R/I/J, optionally branch) and keeps per-class event counters plus a total.

---
 rtl/icnt_pkg.sv | 35 +++
 rtl/instr_class_counter_if.sv | 27 ++
 rtl/icnt_sat_counter.sv | 46 ++++
 rtl/instr_class_counter.sv | 145 ++++++++++++++
 tb/tb_instr_class_counter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/icnt_pkg.sv
// rtl/icnt_pkg.sv - shared class/opcode/state constants and opcode classifier for instr_class_counter
package icnt_pkg;

   localparam int OPC_W = 6;

   localparam logic [1:0] CLS_R = 2'd0;
   localparam logic [1:0] CLS_I = 2'd1;
   localparam logic [1:0] CLS_J = 2'd2;
   localparam logic [1:0] CLS_B = 2'd3;

   localparam logic [OPC_W-1:0] OPC_RTYPE = 6'd0;
   localparam logic [OPC_W-1:0] OPC_J     = 6'd2;
   localparam logic [OPC_W-1:0] OPC_JAL   = 6'd3;
   localparam logic [OPC_W-1:0] OPC_BEQ   = 6'd4;
   localparam logic [OPC_W-1:0] OPC_BNE   = 6'd5;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_UPDATE = 2'd2;

   // Branches only get their own class when split_b is set; otherwise they are I-type.
   function automatic logic [1:0] classify(input logic [OPC_W-1:0] opc, input logic split_b);
      logic [1:0] c;
      if (opc == OPC_RTYPE)
         c = CLS_R;
      else if ((opc == OPC_J) || (opc == OPC_JAL))
         c = CLS_J;
      else if (split_b && ((opc == OPC_BEQ) || (opc == OPC_BNE)))
         c = CLS_B;
      else
         c = CLS_I;
      return c;
   endfunction

endpackage

// File: rtl/instr_class_counter_if.sv
// rtl/instr_class_counter_if.sv - serial input / counter output bundle of instr_class_counter
interface instr_class_counter_if #(
   parameter int CNT_W = 8,
   parameter int TOT_W = 16
);
   logic             bit_in;
   logic             bit_vld;
   logic             clr;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_i;
   logic [CNT_W-1:0] cnt_j;
   logic [CNT_W-1:0] cnt_b;
   logic [TOT_W-1:0] total_o;
   logic [3:0]       ovf_o;
   logic             done_o;
   logic [1:0]       class_o;

   modport master (
      output bit_in, bit_vld, clr,
      input  cnt_r, cnt_i, cnt_j, cnt_b, total_o, ovf_o, done_o, class_o
   );

   modport slave (
      input  bit_in, bit_vld, clr,
      output cnt_r, cnt_i, cnt_j, cnt_b, total_o, ovf_o, done_o, class_o
   );
endinterface

// File: rtl/icnt_sat_counter.sv
// rtl/icnt_sat_counter.sv - per-class event counter with sticky overflow, wrap or saturate
module icnt_sat_counter #(
   parameter int WIDTH    = 8,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] q,
   output logic             ovf
);
   logic [WIDTH-1:0] q_q, q_d;
   logic             ovf_q, ovf_d;

   // Next count: clr dominates; an increment at all-ones flags overflow and wraps or holds.
   always_comb begin
      q_d   = q_q;
      ovf_d = ovf_q;
      if (clr) begin
         q_d   = '0;
         ovf_d = 1'b0;
      end else if (inc) begin
         if (q_q == '1) begin
            ovf_d = 1'b1;
            q_d   = (SATURATE != 0) ? q_q : '0;
         end else begin
            q_d = q_q + WIDTH'(1);
         end
      end
   end

   // Count and sticky flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q   <= '0;
         ovf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         ovf_q <= ovf_d;
      end
   end

   assign q   = q_q;
   assign ovf = ovf_q;
endmodule

// File: rtl/instr_class_counter.sv
// rtl/instr_class_counter.sv - serial MIPS instruction class profiler; ICNT_BRANCH_SPLIT_EN enables branch class
module instr_class_counter
   import icnt_pkg::*;
#(
   parameter int INSTR_W  = 32,
   parameter int CNT_W    = 8,
   parameter int TOT_W    = 16,
   parameter int SATURATE = 0
) (
   input  logic clk,
   input  logic rst,
   instr_class_counter_if.slave bus
);
   localparam int              BC_W     = (INSTR_W > 1) ? $clog2(INSTR_W) : 1;
   localparam logic [BC_W-1:0] BIT_LAST = BC_W'(INSTR_W - 1);

`ifdef ICNT_BRANCH_SPLIT_EN
   localparam logic SPLIT_B = 1'b1;
`else
   localparam logic SPLIT_B = 1'b0;
`endif

   logic [1:0]         state_q, state_d;
   logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [INSTR_W-2:0] sr_q, sr_d;
   logic [OPC_W-1:0]   opc_q, opc_d;
   logic               done_q, done_d;
   logic [1:0]         class_q, class_d;
   logic [TOT_W-1:0]   tot_q, tot_d;

   logic [INSTR_W-1:0] word_full;
   logic               word_done;
   logic               upd;
   logic [1:0]         cls;
   logic               inc_r, inc_i, inc_j;
   logic               ovf_r, ovf_i, ovf_j, ovf_b;

   // The word as it would stand after shifting the current bit in.
   assign word_full = {sr_q, bit_in_w()};

   function automatic logic bit_in_w();
      return bus.bit_in;
   endfunction

   // Shift path: each valid bit shifts in; the last bit of a word latches its opcode.
   always_comb begin
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      opc_d     = opc_q;
      word_done = 1'b0;
      if (bus.clr) begin
         sr_d      = '0;
         bit_cnt_d = '0;
      end else if (bus.bit_vld) begin
         sr_d = word_full[INSTR_W-2:0];
         if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            word_done = 1'b1;
            opc_d     = word_full[INSTR_W-1 -: OPC_W];
         end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
         end
      end
   end

   // Sequencer: UPDATE lasts one cycle after each completed word; shifting never stalls.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = ST_SHIFT;
         ST_SHIFT:  state_d = ST_SHIFT;
         ST_UPDATE: state_d = ST_SHIFT;
         default:   state_d = ST_IDLE;
      endcase
      if (word_done)
         state_d = ST_UPDATE;
   end

   assign upd   = (state_q == ST_UPDATE) && !bus.clr;
   assign cls   = classify(opc_q, SPLIT_B);
   assign inc_r = upd && (cls == CLS_R);
   assign inc_i = upd && (cls == CLS_I);
   assign inc_j = upd && (cls == CLS_J);

   // Result side: total, last class and the done pulse follow the update cycle.
   always_comb begin
      done_d  = upd;
      class_d = class_q;
      tot_d   = tot_q;
      if (bus.clr) begin
         class_d = CLS_R;
         tot_d   = '0;
      end else if (upd) begin
         class_d = cls;
         tot_d   = tot_q + TOT_W'(1);
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         sr_q      <= '0;
         opc_q     <= '0;
         done_q    <= 1'b0;
         class_q   <= CLS_R;
         tot_q     <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         sr_q      <= sr_d;
         opc_q     <= opc_d;
         done_q    <= done_d;
         class_q   <= class_d;
         tot_q     <= tot_d;
      end
   end

   icnt_sat_counter #(.WIDTH(CNT_W), .SATURATE(SATURATE)) u_cnt_r (
      .clk(clk), .rst(rst), .inc(inc_r), .clr(bus.clr), .q(bus.cnt_r), .ovf(ovf_r)
   );
   icnt_sat_counter #(.WIDTH(CNT_W), .SATURATE(SATURATE)) u_cnt_i (
      .clk(clk), .rst(rst), .inc(inc_i), .clr(bus.clr), .q(bus.cnt_i), .ovf(ovf_i)
   );
   icnt_sat_counter #(.WIDTH(CNT_W), .SATURATE(SATURATE)) u_cnt_j (
      .clk(clk), .rst(rst), .inc(inc_j), .clr(bus.clr), .q(bus.cnt_j), .ovf(ovf_j)
   );

`ifdef ICNT_BRANCH_SPLIT_EN
   logic inc_b;
   assign inc_b = upd && (cls == CLS_B);
   icnt_sat_counter #(.WIDTH(CNT_W), .SATURATE(SATURATE)) u_cnt_b (
      .clk(clk), .rst(rst), .inc(inc_b), .clr(bus.clr), .q(bus.cnt_b), .ovf(ovf_b)
   );
`else
   assign ovf_b     = 1'b0;
   assign bus.cnt_b = '0;
`endif

   assign bus.ovf_o   = {ovf_b, ovf_j, ovf_i, ovf_r};
   assign bus.done_o  = done_q;
   assign bus.class_o = class_q;
   assign bus.total_o = tot_q;
endmodule

// File: tb/tb_instr_class_counter.sv
// tb/tb_instr_class_counter.sv - directed bench for instr_class_counter (honours ICNT_BRANCH_SPLIT_EN)
module tb_instr_class_counter;
   import icnt_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tb_bit_in  = 1'b0;
   logic tb_bit_vld = 1'b0;
   logic tb_clr     = 1'b0;

   always #5 clk = ~clk;

   instr_class_counter_if #(.CNT_W(8), .TOT_W(16)) bus0 ();
   instr_class_counter_if #(.CNT_W(3), .TOT_W(16)) bus_w0 ();
   instr_class_counter_if #(.CNT_W(3), .TOT_W(16)) bus_w1 ();

   assign bus0.bit_in    = tb_bit_in;
   assign bus0.bit_vld   = tb_bit_vld;
   assign bus0.clr       = tb_clr;
   assign bus_w0.bit_in  = tb_bit_in;
   assign bus_w0.bit_vld = tb_bit_vld;
   assign bus_w0.clr     = tb_clr;
   assign bus_w1.bit_in  = tb_bit_in;
   assign bus_w1.bit_vld = tb_bit_vld;
   assign bus_w1.clr     = tb_clr;

   instr_class_counter #(.INSTR_W(32), .CNT_W(8), .TOT_W(16), .SATURATE(0)) dut (
      .clk(clk), .rst(rst), .bus(bus0)
   );
   instr_class_counter #(.INSTR_W(32), .CNT_W(3), .TOT_W(16), .SATURATE(0)) dut_w0 (
      .clk(clk), .rst(rst), .bus(bus_w0)
   );
   instr_class_counter #(.INSTR_W(32), .CNT_W(3), .TOT_W(16), .SATURATE(1)) dut_w1 (
      .clk(clk), .rst(rst), .bus(bus_w1)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int done_cnt = 0;
   int done_last = 0;
   int done_prev = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus0.done_o === 1'b1) begin
         done_cnt  = done_cnt + 1;
         done_prev = done_last;
         done_last = cyc;
      end
   end

   typedef struct {
      logic [31:0] word;
      logic [1:0]  cls;
      logic [7:0]  r;
      logic [7:0]  i;
      logic [7:0]  j;
      logic [7:0]  b;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_word(input logic [31:0] w, input bit gap);
      for (int k = 31; k >= 0; k--) begin
         if (gap) begin
            tb_bit_vld = 1'b0;
            tick();
         end
         tb_bit_in  = w[k];
         tb_bit_vld = 1'b1;
         tick();
      end
      tb_bit_vld = 1'b0;
      tb_bit_in  = 1'b0;
   endtask

   task automatic shift_ones(input int n);
      for (int k = 0; k < n; k++) begin
         tb_bit_in  = 1'b1;
         tb_bit_vld = 1'b1;
         tick();
      end
      tb_bit_vld = 1'b0;
      tb_bit_in  = 1'b0;
   endtask

   // clr is applied together with a valid '1' bit, which must be dropped.
   task automatic do_clr();
      tb_clr     = 1'b1;
      tb_bit_vld = 1'b1;
      tb_bit_in  = 1'b1;
      tick();
      tb_clr     = 1'b0;
      tb_bit_vld = 1'b0;
      tb_bit_in  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      vecs[0] = '{32'h00000020, CLS_R, 8'd1, 8'd0, 8'd0, 8'd0};
      vecs[1] = '{32'h08000000, CLS_J, 8'd0, 8'd0, 8'd1, 8'd0};
      vecs[2] = '{32'h0C000000, CLS_J, 8'd0, 8'd0, 8'd1, 8'd0};
`ifdef ICNT_BRANCH_SPLIT_EN
      vecs[3] = '{32'h10000000, CLS_B, 8'd0, 8'd0, 8'd0, 8'd1};
      vecs[4] = '{32'h14000000, CLS_B, 8'd0, 8'd0, 8'd0, 8'd1};
`else
      vecs[3] = '{32'h10000000, CLS_I, 8'd0, 8'd1, 8'd0, 8'd0};
      vecs[4] = '{32'h14000000, CLS_I, 8'd0, 8'd1, 8'd0, 8'd0};
`endif
      vecs[5] = '{32'h20000000, CLS_I, 8'd0, 8'd1, 8'd0, 8'd0};
      vecs[6] = '{32'hFC000000, CLS_I, 8'd0, 8'd1, 8'd0, 8'd0};
      vecs[7] = '{32'h04000000, CLS_I, 8'd0, 8'd1, 8'd0, 8'd0};
      vecs[8] = '{32'h03FFFFFF, CLS_R, 8'd1, 8'd0, 8'd0, 8'd0};
      vecs[9] = '{32'h18000000, CLS_I, 8'd0, 8'd1, 8'd0, 8'd0};

      // Reset state
      tick();
      tick();
      check("rst cnt_r", 32'(bus0.cnt_r), 32'd0);
      check("rst cnt_i", 32'(bus0.cnt_i), 32'd0);
      check("rst total", 32'(bus0.total_o), 32'd0);
      check("rst ovf", 32'(bus0.ovf_o), 32'd0);
      check("rst done", 32'(bus0.done_o), 32'd0);
      check("rst class", 32'(bus0.class_o), 32'd0);
      rst = 1'b0;

      // First word right after reset: update lands on edge 33
      shift_word(32'h00000020, 1'b0);
      check("lat edge32 cnt_r", 32'(bus0.cnt_r), 32'd0);
      check("lat edge32 done", 32'(bus0.done_o), 32'd0);
      tick();
      check("lat edge33 cnt_r", 32'(bus0.cnt_r), 32'd1);
      check("lat edge33 total", 32'(bus0.total_o), 32'd1);
      check("lat edge33 class", 32'(bus0.class_o), 32'(CLS_R));
      check("lat edge33 done", 32'(bus0.done_o), 32'd1);
      tick();
      check("lat done low", 32'(bus0.done_o), 32'd0);
      check("lat done pulses", 32'(done_cnt), 32'd1);

      // Table of single words, each after a clr
      for (int v = 0; v < 10; v++) begin
         do_clr();
         shift_word(vecs[v].word, 1'b0);
         tick();
         check($sformatf("v%0d done", v), 32'(bus0.done_o), 32'd1);
         check($sformatf("v%0d class", v), 32'(bus0.class_o), 32'(vecs[v].cls));
         check($sformatf("v%0d cnt_r", v), 32'(bus0.cnt_r), 32'(vecs[v].r));
         check($sformatf("v%0d cnt_i", v), 32'(bus0.cnt_i), 32'(vecs[v].i));
         check($sformatf("v%0d cnt_j", v), 32'(bus0.cnt_j), 32'(vecs[v].j));
         check($sformatf("v%0d cnt_b", v), 32'(bus0.cnt_b), 32'(vecs[v].b));
         check($sformatf("v%0d total", v), 32'(bus0.total_o), 32'd1);
         tick();
         check($sformatf("v%0d done low", v), 32'(bus0.done_o), 32'd0);
      end

      // Back-to-back j / jal
      do_clr();
      d0 = done_cnt;
      shift_word(32'h08000000, 1'b0);
      shift_word(32'h0C000000, 1'b0);
      tick();
      tick();
      check("b2b cnt_j", 32'(bus0.cnt_j), 32'd2);
      check("b2b total", 32'(bus0.total_o), 32'd2);
      check("b2b pulses", 32'(done_cnt - d0), 32'd2);
      check("b2b spacing", 32'(done_last - done_prev), 32'd32);

      // Nine R words into 3-bit counters: wrap vs saturate
      do_clr();
      for (int n = 0; n < 9; n++) shift_word(32'h00000020, 1'b0);
      tick();
      check("wrap cnt_r", 32'(bus_w0.cnt_r), 32'd1);
      check("wrap ovf", 32'(bus_w0.ovf_o), 32'h1);
      check("sat cnt_r", 32'(bus_w1.cnt_r), 32'd7);
      check("sat ovf", 32'(bus_w1.ovf_o), 32'h1);
      check("wide cnt_r", 32'(bus0.cnt_r), 32'd9);
      check("wide ovf", 32'(bus0.ovf_o), 32'h0);
      check("w3 total", 32'(bus_w0.total_o), 32'd9);
      do_clr();
      check("ovf cleared", 32'(bus_w0.ovf_o), 32'h0);

      // Partial word discarded by clr
      do_clr();
      shift_ones(10);
      do_clr();
      shift_word(32'h20000000, 1'b0);
      tick();
      check("pclr cnt_i", 32'(bus0.cnt_i), 32'd1);
      check("pclr total", 32'(bus0.total_o), 32'd1);
      check("pclr others", 32'(bus0.cnt_r) + 32'(bus0.cnt_j) + 32'(bus0.cnt_b), 32'd0);

      // Partial word discarded by reset
      do_clr();
      shift_ones(10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      shift_word(32'h20000000, 1'b0);
      tick();
      check("prst cnt_i", 32'(bus0.cnt_i), 32'd1);
      check("prst total", 32'(bus0.total_o), 32'd1);
      check("prst others", 32'(bus0.cnt_r) + 32'(bus0.cnt_j) + 32'(bus0.cnt_b), 32'd0);

      // Gapped input, one bit every other cycle
      do_clr();
      shift_word(32'h00000020, 1'b1);
      tick();
      check("gap cnt_r", 32'(bus0.cnt_r), 32'd1);
      check("gap done", 32'(bus0.done_o), 32'd1);

      // clr on the UPDATE edge suppresses the count and done
      do_clr();
      d0 = done_cnt;
      shift_word(32'h00000020, 1'b1);
      tb_clr = 1'b1;
      tick();
      tb_clr = 1'b0;
      check("updclr cnt_r", 32'(bus0.cnt_r), 32'd0);
      check("updclr total", 32'(bus0.total_o), 32'd0);
      check("updclr done", 32'(bus0.done_o), 32'd0);
      tick();
      tick();
      check("updclr pulses", 32'(done_cnt - d0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
